// File: rtl/axis_pkt_checker.sv
// AXI-Stream sink/monitor: drives tready with a programmable backpressure pattern,
// measures packets, checks framing rules and keeps live and snapshot statistics.
module axis_pkt_checker #(
    parameter int ID_WIDTH    = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int TKEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ID_WIDTH-1:0]    s_axis_tid_i,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata_i,
    input  logic                   s_axis_tvalid_i,
    input  logic                   s_axis_tlast_i,
    input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep_i,
    output logic                   s_axis_tready_o,
    input  logic [1:0]             cfg_bp_mode_i,
    input  logic [7:0]             cfg_bp_on_i,
    input  logic [7:0]             cfg_bp_off_i,
    input  logic [7:0]             cfg_bp_thr_i,
    input  logic                   clear_i,
    input  logic                   snap_i,
    output logic [31:0]            stat_pkt_cnt_o,
    output logic [47:0]            stat_byte_cnt_o,
    output logic [31:0]            stat_err_cnt_o,
    output logic [15:0]            stat_min_len_o,
    output logic [15:0]            stat_max_len_o,
    output logic [15:0]            last_len_o,
    output logic [ID_WIDTH-1:0]    last_id_o,
    output logic [3:0]             err_flags_o,
    output logic                   pkt_done_o,
    output logic [31:0]            snap_pkt_cnt_o,
    output logic [47:0]            snap_byte_cnt_o,
    output logic [31:0]            snap_err_cnt_o
);

    localparam logic [TKEEP_WIDTH-1:0] KEEP_ALL = '1;
    localparam logic [TKEEP_WIDTH-1:0] KEEP_ONE = 1;

    typedef enum logic {IDLE, IN_PKT} state_t;

    function automatic logic [15:0] popcount(input logic [TKEEP_WIDTH-1:0] k);
        logic [15:0] c;
        c = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) c = c + 16'(k[i]);
        return c;
    endfunction

    // A valid last-beat keep is a run of ones starting at bit 0 (k & (k+1) clears it).
    function automatic logic keep_contig(input logic [TKEEP_WIDTH-1:0] k);
        return ((k & (k + KEEP_ONE)) == '0);
    endfunction

    // Returns {overflow, saturated sum}.
    function automatic logic [16:0] len_sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? {1'b1, 16'hFFFF} : s;
    endfunction

    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata_i;

    // ---------------- backpressure generator ----------------
    logic [1:0]  mode_q;
    logic        phase_off_q, phase_off_d;
    logic [7:0]  duty_cnt_q, duty_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        tready_q, tready_d;
    logic [7:0]  on_len;

    always_comb begin
        on_len      = (cfg_bp_on_i == 8'd0) ? 8'd1 : cfg_bp_on_i;
        phase_off_d = phase_off_q;
        duty_cnt_d  = duty_cnt_q;
        lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        if (cfg_bp_mode_i != mode_q) begin
            phase_off_d = 1'b0;
            duty_cnt_d  = 8'd0;
        end else if (cfg_bp_mode_i == 2'b01) begin
            if (!phase_off_q) begin
                if ({1'b0, duty_cnt_q} + 9'd1 >= {1'b0, on_len}) begin
                    duty_cnt_d  = 8'd0;
                    phase_off_d = (cfg_bp_off_i != 8'd0);
                end else begin
                    duty_cnt_d = duty_cnt_q + 8'd1;
                end
            end else begin
                if ({1'b0, duty_cnt_q} + 9'd1 >= {1'b0, cfg_bp_off_i}) begin
                    duty_cnt_d  = 8'd0;
                    phase_off_d = 1'b0;
                end else begin
                    duty_cnt_d = duty_cnt_q + 8'd1;
                end
            end
        end
        case (cfg_bp_mode_i)
            2'b00:   tready_d = 1'b1;
            2'b01:   tready_d = !phase_off_d;
            2'b10:   tready_d = (lfsr_q[7:0] >= cfg_bp_thr_i);
            default: tready_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= 2'b00;
            phase_off_q <= 1'b0;
            duty_cnt_q  <= 8'd0;
            lfsr_q      <= 16'hACE1;
            tready_q    <= 1'b0;
        end else begin
            mode_q      <= cfg_bp_mode_i;
            phase_off_q <= phase_off_d;
            duty_cnt_q  <= duty_cnt_d;
            lfsr_q      <= lfsr_d;
            tready_q    <= tready_d;
        end
    end

    assign s_axis_tready_o = tready_q;

    // ---------------- packet framing ----------------
    state_t              state_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [15:0]         len_q;
    logic [3:0]          perr_q;
    logic                done_q;

    logic                accept, complete, ovf;
    logic [15:0]         beat_len, new_len;
    logic [3:0]          beat_err, pkt_err;
    logic [ID_WIDTH-1:0] pkt_id;

    always_comb begin
        accept         = s_axis_tvalid_i & tready_q;
        complete       = accept & s_axis_tlast_i;
        beat_len       = popcount(s_axis_tkeep_i);
        {ovf, new_len} = len_sat_add((state_q == IDLE) ? 16'd0 : len_q, beat_len);
        beat_err[0]    = (state_q == IN_PKT) && (s_axis_tid_i != id_q);
        beat_err[1]    = s_axis_tlast_i ? !keep_contig(s_axis_tkeep_i)
                                        : (s_axis_tkeep_i != KEEP_ALL);
        beat_err[2]    = ovf;
        beat_err[3]    = (s_axis_tkeep_i == '0);
        pkt_err        = ((state_q == IN_PKT) ? perr_q : 4'd0) | beat_err;
        pkt_id         = (state_q == IDLE) ? s_axis_tid_i : id_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            len_q   <= 16'd0;
            perr_q  <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= complete;
            if (accept) begin
                if (s_axis_tlast_i) begin
                    state_q <= IDLE;
                end else begin
                    state_q <= IN_PKT;
                    id_q    <= pkt_id;
                    len_q   <= new_len;
                    perr_q  <= pkt_err;
                end
            end
        end
    end

    assign pkt_done_o = done_q;

    // ---------------- statistics ----------------
    logic [31:0]         pkt_cnt_q, err_cnt_q, snap_pkt_q, snap_err_q;
    logic [47:0]         byte_cnt_q, snap_byte_q;
    logic [15:0]         min_len_q, max_len_q, last_len_q;
    logic [ID_WIDTH-1:0] last_id_q;
    logic [3:0]          flags_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_cnt_q   <= 32'd0;
            byte_cnt_q  <= 48'd0;
            err_cnt_q   <= 32'd0;
            min_len_q   <= 16'hFFFF;
            max_len_q   <= 16'd0;
            last_len_q  <= 16'd0;
            last_id_q   <= '0;
            flags_q     <= 4'd0;
            snap_pkt_q  <= 32'd0;
            snap_byte_q <= 48'd0;
            snap_err_q  <= 32'd0;
        end else begin
            // Snapshot sees the pre-update values, including when clear fires alongside.
            if (snap_i) begin
                snap_pkt_q  <= pkt_cnt_q;
                snap_byte_q <= byte_cnt_q;
                snap_err_q  <= err_cnt_q;
            end
            if (clear_i) begin
                pkt_cnt_q  <= 32'd0;
                byte_cnt_q <= 48'd0;
                err_cnt_q  <= 32'd0;
                min_len_q  <= 16'hFFFF;
                max_len_q  <= 16'd0;
                last_len_q <= 16'd0;
                last_id_q  <= '0;
                flags_q    <= 4'd0;
            end else begin
                if (accept) byte_cnt_q <= byte_cnt_q + 48'(beat_len);
                if (complete) begin
                    pkt_cnt_q  <= pkt_cnt_q + 32'd1;
                    last_len_q <= new_len;
                    last_id_q  <= pkt_id;
                    if (new_len < min_len_q) min_len_q <= new_len;
                    if (new_len > max_len_q) max_len_q <= new_len;
                    if (pkt_err != 4'd0) err_cnt_q <= err_cnt_q + 32'd1;
                    flags_q <= flags_q | pkt_err;
                end
            end
        end
    end

    assign stat_pkt_cnt_o  = pkt_cnt_q;
    assign stat_byte_cnt_o = byte_cnt_q;
    assign stat_err_cnt_o  = err_cnt_q;
    assign stat_min_len_o  = min_len_q;
    assign stat_max_len_o  = max_len_q;
    assign last_len_o      = last_len_q;
    assign last_id_o       = last_id_q;
    assign err_flags_o     = flags_q;
    assign snap_pkt_cnt_o  = snap_pkt_q;
    assign snap_byte_cnt_o = snap_byte_q;
    assign snap_err_cnt_o  = snap_err_q;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed bench for axis_pkt_checker: backpressure modes, packet stats, framing errors,
// clear/snap interaction and reset in the middle of a packet.
module tb_axis_pkt_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  s_axis_tid_i;
    logic [31:0] s_axis_tdata_i;
    logic        s_axis_tvalid_i;
    logic        s_axis_tlast_i;
    logic [3:0]  s_axis_tkeep_i;
    logic        s_axis_tready_o;
    logic [1:0]  cfg_bp_mode_i;
    logic [7:0]  cfg_bp_on_i, cfg_bp_off_i, cfg_bp_thr_i;
    logic        clear_i, snap_i;
    logic [31:0] stat_pkt_cnt_o, stat_err_cnt_o, snap_pkt_cnt_o, snap_err_cnt_o;
    logic [47:0] stat_byte_cnt_o, snap_byte_cnt_o;
    logic [15:0] stat_min_len_o, stat_max_len_o, last_len_o;
    logic [9:0]  last_id_o;
    logic [3:0]  err_flags_o;
    logic        pkt_done_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] pat;

    axis_pkt_checker dut (
        .clk             (clk),
        .reset           (reset),
        .s_axis_tid_i    (s_axis_tid_i),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tlast_i  (s_axis_tlast_i),
        .s_axis_tkeep_i  (s_axis_tkeep_i),
        .s_axis_tready_o (s_axis_tready_o),
        .cfg_bp_mode_i   (cfg_bp_mode_i),
        .cfg_bp_on_i     (cfg_bp_on_i),
        .cfg_bp_off_i    (cfg_bp_off_i),
        .cfg_bp_thr_i    (cfg_bp_thr_i),
        .clear_i         (clear_i),
        .snap_i          (snap_i),
        .stat_pkt_cnt_o  (stat_pkt_cnt_o),
        .stat_byte_cnt_o (stat_byte_cnt_o),
        .stat_err_cnt_o  (stat_err_cnt_o),
        .stat_min_len_o  (stat_min_len_o),
        .stat_max_len_o  (stat_max_len_o),
        .last_len_o      (last_len_o),
        .last_id_o       (last_id_o),
        .err_flags_o     (err_flags_o),
        .pkt_done_o      (pkt_done_o),
        .snap_pkt_cnt_o  (snap_pkt_cnt_o),
        .snap_byte_cnt_o (snap_byte_cnt_o),
        .snap_err_cnt_o  (snap_err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [9:0] id, input logic [3:0] keep, input logic last);
        logic acc;
        int   guard;
        guard           = 0;
        s_axis_tvalid_i = 1'b1;
        s_axis_tid_i    = id;
        s_axis_tkeep_i  = keep;
        s_axis_tlast_i  = last;
        s_axis_tdata_i  = $urandom;
        do begin
            acc = s_axis_tready_o;
            tick();
            guard++;
        end while (!acc && guard < 200);
        s_axis_tvalid_i = 1'b0;
        s_axis_tlast_i  = 1'b0;
        chk("beat_accepted", {63'd0, acc}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        s_axis_tid_i = '0; s_axis_tdata_i = '0; s_axis_tvalid_i = 1'b0;
        s_axis_tlast_i = 1'b0; s_axis_tkeep_i = '0;
        cfg_bp_mode_i = 2'b00; cfg_bp_on_i = 8'd0; cfg_bp_off_i = 8'd0; cfg_bp_thr_i = 8'd0;
        clear_i = 1'b0; snap_i = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_tready",  s_axis_tready_o, 0);
        chk("rst_pkt",     stat_pkt_cnt_o, 0);
        chk("rst_byte",    stat_byte_cnt_o, 0);
        chk("rst_err",     stat_err_cnt_o, 0);
        chk("rst_min",     stat_min_len_o, 16'hFFFF);
        chk("rst_max",     stat_max_len_o, 0);
        chk("rst_lastlen", last_len_o, 0);
        chk("rst_flags",   err_flags_o, 0);
        chk("rst_done",    pkt_done_o, 0);
        chk("rst_snap",    snap_pkt_cnt_o, 0);
        reset = 1'b0;
        tick();
        chk("m00_tready", s_axis_tready_o, 1);

        // Mode 00: three 8-byte packets on tid 5
        for (int i = 0; i < 3; i++) begin
            send_beat(10'd5, 4'hF, 1'b0);
            send_beat(10'd5, 4'hF, 1'b1);
        end
        chk("a_done_pulse", pkt_done_o, 1);
        tick();
        chk("a_done_clear", pkt_done_o, 0);
        chk("a_pkt",     stat_pkt_cnt_o, 3);
        chk("a_byte",    stat_byte_cnt_o, 24);
        chk("a_min",     stat_min_len_o, 8);
        chk("a_max",     stat_max_len_o, 8);
        chk("a_err",     stat_err_cnt_o, 0);
        chk("a_lastid",  last_id_o, 5);
        chk("a_lastlen", last_len_o, 8);
        chk("a_flags",   err_flags_o, 0);

        // Mode 01 on=2 off=3, tvalid held with single-beat 4-byte packets on tid 7
        cfg_bp_mode_i = 2'b01; cfg_bp_on_i = 8'd2; cfg_bp_off_i = 8'd3;
        s_axis_tvalid_i = 1'b1; s_axis_tid_i = 10'd7; s_axis_tkeep_i = 4'hF; s_axis_tlast_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            pat[9-i] = s_axis_tready_o;
        end
        s_axis_tvalid_i = 1'b0; s_axis_tlast_i = 1'b0;
        chk("duty_pattern", pat, 10'b1100011000);
        chk("duty_pkt",     stat_pkt_cnt_o, 8);
        chk("duty_byte",    stat_byte_cnt_o, 44);
        chk("duty_min",     stat_min_len_o, 4);

        // 13-byte packet under duty-cycle backpressure
        send_beat(10'd9, 4'hF, 1'b0);
        send_beat(10'd9, 4'hF, 1'b0);
        send_beat(10'd9, 4'hF, 1'b0);
        send_beat(10'd9, 4'h1, 1'b1);
        chk("b13_lastlen", last_len_o, 13);
        chk("b13_max",     stat_max_len_o, 13);
        chk("b13_pkt",     stat_pkt_cnt_o, 9);
        chk("b13_byte",    stat_byte_cnt_o, 57);
        chk("b13_lastid",  last_id_o, 9);

        // Mode 11 never ready, mode 10 with thr=0 always ready
        cfg_bp_mode_i = 2'b11;
        tick();
        chk("m11_tready_a", s_axis_tready_o, 0);
        tick();
        chk("m11_tready_b", s_axis_tready_o, 0);
        cfg_bp_mode_i = 2'b10; cfg_bp_thr_i = 8'd0;
        tick();
        chk("m10_thr0", s_axis_tready_o, 1);
        cfg_bp_mode_i = 2'b00;
        tick();

        // Clear alone
        clear_pulse();
        chk("clr_pkt",  stat_pkt_cnt_o, 0);
        chk("clr_byte", stat_byte_cnt_o, 0);
        chk("clr_min",  stat_min_len_o, 16'hFFFF);
        chk("clr_max",  stat_max_len_o, 0);
        chk("clr_last", last_len_o, 0);

        // tid change 5 -> 6 on beat 2 of 3
        send_beat(10'd5, 4'hF, 1'b0);
        send_beat(10'd6, 4'hF, 1'b0);
        send_beat(10'd5, 4'hF, 1'b1);
        chk("tid_flags",   err_flags_o, 4'b0001);
        chk("tid_errcnt",  stat_err_cnt_o, 1);
        chk("tid_pkt",     stat_pkt_cnt_o, 1);
        chk("tid_lastid",  last_id_o, 5);
        chk("tid_lastlen", last_len_o, 12);

        // Non-contiguous last-beat keep
        clear_pulse();
        send_beat(10'd1, 4'b0101, 1'b1);
        chk("keep_last_flags",  err_flags_o, 4'b0010);
        chk("keep_last_errcnt", stat_err_cnt_o, 1);
        chk("keep_last_len",    last_len_o, 2);

        // Partial non-last beat
        clear_pulse();
        send_beat(10'd1, 4'b0111, 1'b0);
        send_beat(10'd1, 4'hF, 1'b1);
        chk("keep_mid_flags", err_flags_o, 4'b0010);
        chk("keep_mid_len",   last_len_o, 7);

        // Zero-keep beat
        clear_pulse();
        send_beat(10'd1, 4'b0000, 1'b1);
        chk("keep0_flags", err_flags_o, 4'b1000);
        chk("keep0_len",   last_len_o, 0);
        chk("keep0_min",   stat_min_len_o, 0);

        // Clear and snap coincident with a tlast accept
        clear_pulse();
        send_beat(10'd4, 4'hF, 1'b1);
        chk("cs_pre_pkt", stat_pkt_cnt_o, 1);
        send_beat(10'd3, 4'hF, 1'b0);
        chk("cs_pre_byte", stat_byte_cnt_o, 8);
        chk("cs_ready", s_axis_tready_o, 1);
        s_axis_tvalid_i = 1'b1; s_axis_tid_i = 10'd3; s_axis_tkeep_i = 4'hF; s_axis_tlast_i = 1'b1;
        clear_i = 1'b1; snap_i = 1'b1;
        tick();
        clear_i = 1'b0; snap_i = 1'b0; s_axis_tvalid_i = 1'b0; s_axis_tlast_i = 1'b0;
        chk("cs_done",      pkt_done_o, 1);
        chk("cs_pkt",       stat_pkt_cnt_o, 0);
        chk("cs_byte",      stat_byte_cnt_o, 0);
        chk("cs_min",       stat_min_len_o, 16'hFFFF);
        chk("cs_lastlen",   last_len_o, 0);
        chk("cs_snap_pkt",  snap_pkt_cnt_o, 1);
        chk("cs_snap_byte", snap_byte_cnt_o, 8);
        chk("cs_snap_err",  snap_err_cnt_o, 0);

        // Reset mid-packet, then a 1-beat 2-byte packet
        send_beat(10'd2, 4'hF, 1'b0);
        reset = 1'b1;
        #1;
        chk("mr_async_tready", s_axis_tready_o, 0);
        tick();
        reset = 1'b0;
        send_beat(10'd1, 4'b0011, 1'b1);
        chk("mr_pkt",     stat_pkt_cnt_o, 1);
        chk("mr_lastlen", last_len_o, 2);
        chk("mr_flags",   err_flags_o, 0);
        chk("mr_errcnt",  stat_err_cnt_o, 0);
        chk("mr_byte",    stat_byte_cnt_o, 2);
        chk("mr_lastid",  last_id_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
